// File: rtl/reg_bus_arb_pkg.sv
// Purpose: shared widths and FSM encoding for the register-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bus_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bus_arb_req_slot.sv
// Purpose: one-deep request slot per requester (pending latch, field capture, overflow pulse).
// Latency: request visible as pending one cycle after the sampling edge.
// Backpressure: a request hitting a full slot that is not being released is dropped and flagged on ovf.
//
// Ports: req/we/addr/wdata from the requester; rel frees the slot at the next edge;
//        pending/slot_* expose the held request; ovf pulses one cycle per dropped request.
module req_slot #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rel,
    output logic              pending,
    output logic              slot_we,
    output logic [ADDR_W-1:0] slot_addr,
    output logic [DATA_W-1:0] slot_wdata,
    output logic              ovf
);

    // A release on the same edge frees the slot in time for the new request.
    logic accept;
    assign accept = req && (!pending || rel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            ovf        <= 1'b0;
        end else begin
            ovf <= req && pending && !rel;
            if (accept) begin
                pending    <= 1'b1;
                slot_we    <= we;
                slot_addr  <= addr;
                slot_wdata <= wdata;
            end else if (rel) begin
                pending    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Purpose: arbitrates two register requesters onto one read/write strobe bus.
// Latency: strobe one cycle after request is held, read data one cycle after the strobe; one access per 2 cycles.
// Backpressure: none on the bus; requesters see busy while their slot is held and ovf when a request is dropped.
//
// Ports: clk/rst_n; rk_req/we/addr/wdata in and rk_busy/rvalid/rdata/ovf out per requester k=0,1;
//        bus side read/write strobes, addr, data_write out, data_read in (combinational from addr).
module reg_bus_arb
    import reg_bus_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_busy,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ovf,
    output logic              r1_busy,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ovf,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;      // slot owning the current access (0 or 1)
    logic              last_gnt;
    logic              start;

    logic              p0, p1;
    logic              s0_we, s1_we;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic [DATA_W-1:0] s0_wdata, s1_wdata;
    logic              rel0, rel1;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Slots are freed at the closing edge of their ISSUE cycle.
    assign rel0 = (state_q == ISSUE) && !gnt_q;
    assign rel1 = (state_q == ISSUE) &&  gnt_q;

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (r0_req),
        .we         (r0_we),
        .addr       (r0_addr),
        .wdata      (r0_wdata),
        .rel        (rel0),
        .pending    (p0),
        .slot_we    (s0_we),
        .slot_addr  (s0_addr),
        .slot_wdata (s0_wdata),
        .ovf        (r0_ovf)
    );

    req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (r1_req),
        .we         (r1_we),
        .addr       (r1_addr),
        .wdata      (r1_wdata),
        .rel        (rel1),
        .pending    (p1),
        .slot_we    (s1_we),
        .slot_addr  (s1_addr),
        .slot_wdata (s1_wdata),
        .ovf        (r1_ovf)
    );

    assign r0_busy = p0;
    assign r1_busy = p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant choice. On a tie the slot that did not win last time goes.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0 || p1) begin
                    start   = 1'b1;
                    state_d = ISSUE;
                    gnt_d   = (p0 && p1) ? ~last_gnt : p1;
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_we    = gnt_d ? s1_we    : s0_we;
    assign sel_addr  = gnt_d ? s1_addr  : s0_addr;
    assign sel_wdata = gnt_d ? s1_wdata : s0_wdata;

    // Bus strobes and read-return path. addr/data_write keep their values outside a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= 1'b0;
            last_gnt   <= 1'b1;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_write <= '0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            if (start) begin
                gnt_q      <= gnt_d;
                last_gnt   <= gnt_d;
                read       <= !sel_we;
                write      <= sel_we;
                addr       <= sel_addr;
                data_write <= sel_we ? sel_wdata : '0;
            end else if (state_q == ISSUE) begin
                read  <= 1'b0;
                write <= 1'b0;
                if (read) begin
                    if (gnt_q) begin
                        r1_rvalid <= 1'b1;
                        r1_rdata  <= data_read;
                    end else begin
                        r0_rvalid <= 1'b1;
                        r0_rdata  <= data_read;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arb.sv
// Purpose: self-checking bench for reg_bus_arb (vector table, directed corner cases, random scoreboard run).
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_bus_arb;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_busy, r0_rvalid, r0_ovf, r1_busy, r1_rvalid, r1_ovf;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          read, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_write, data_read;

    always #5 clk = ~clk;

    // Register file model: each address returns a fixed pattern.
    function automatic logic [DW-1:0] rd_model(logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a} ^ 8'h2E;
    endfunction

    assign data_read = rd_model(addr);

    reg_bus_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_req     (r0_req),
        .r0_we      (r0_we),
        .r0_addr    (r0_addr),
        .r0_wdata   (r0_wdata),
        .r1_req     (r1_req),
        .r1_we      (r1_we),
        .r1_addr    (r1_addr),
        .r1_wdata   (r1_wdata),
        .r0_busy    (r0_busy),
        .r0_rvalid  (r0_rvalid),
        .r0_rdata   (r0_rdata),
        .r0_ovf     (r0_ovf),
        .r1_busy    (r1_busy),
        .r1_rvalid  (r1_rvalid),
        .r1_rdata   (r1_rdata),
        .r1_ovf     (r1_ovf),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
    } acc_t;

    typedef struct packed {
        logic k;
        acc_t a;
    } sb_t;

    typedef struct {
        int            k;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_dw;
        logic [DW-1:0] exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Scoreboard and reference state
    sb_t           sb[$];
    int            served[$];
    logic          pend[2];
    logic          ovf_exp[2];
    logic          rv_exp[2];
    logic [DW-1:0] rd_exp[2];
    logic [DW-1:0] last_rd[2];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_dw;
    logic          prev_strobe;
    int            issuing;
    int            n_acc, n_srv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            pend[k]    = 1'b0;
            ovf_exp[k] = 1'b0;
            rv_exp[k]  = 1'b0;
            rd_exp[k]  = '0;
            last_rd[k] = '0;
        end
        last_addr   = '0;
        last_dw     = '0;
        prev_strobe = 1'b0;
        issuing     = -1;
    endtask

    task automatic check_reset_outs();
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dw", data_write, 0);
        chk("rst_busy0", r0_busy, 0);
        chk("rst_busy1", r1_busy, 0);
        chk("rst_rv0", r0_rvalid, 0);
        chk("rst_rv1", r1_rvalid, 0);
        chk("rst_rd0", r0_rdata, 0);
        chk("rst_rd1", r1_rdata, 0);
        chk("rst_ovf0", r0_ovf, 0);
        chk("rst_ovf1", r1_ovf, 0);
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (k == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end
    endtask

    // One clock: predict acceptance for the coming edge, then check every output after it.
    task automatic cyc();
        logic rq[2];
        acc_t a[2];
        logic busy_k, rv_k, ovf_k;
        logic [DW-1:0] rdat_k;
        int   hit;
        rq[0] = r0_req;
        rq[1] = r1_req;
        a[0]  = '{we: r0_we, ad: r0_addr, wd: r0_wdata};
        a[1]  = '{we: r1_we, ad: r1_addr, wd: r1_wdata};
        for (int k = 0; k < 2; k++) begin
            ovf_exp[k] = 1'b0;
            if (rq[k]) begin
                if (!pend[k] || issuing == k) begin
                    sb.push_back('{k: k[0], a: a[k]});
                    pend[k] = 1'b1;
                    n_acc++;
                end else begin
                    ovf_exp[k] = 1'b1;
                end
            end else if (issuing == k) begin
                pend[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        r0_req = 1'b0;
        r1_req = 1'b0;

        chk("rw_overlap", {31'd0, read && write}, 0);
        for (int k = 0; k < 2; k++) begin
            busy_k = (k == 0) ? r0_busy   : r1_busy;
            rv_k   = (k == 0) ? r0_rvalid : r1_rvalid;
            ovf_k  = (k == 0) ? r0_ovf    : r1_ovf;
            rdat_k = (k == 0) ? r0_rdata  : r1_rdata;
            chk("busy", busy_k, pend[k]);
            chk("ovf", ovf_k, ovf_exp[k]);
            chk("rvalid", rv_k, rv_exp[k]);
            if (rv_exp[k]) last_rd[k] = rd_exp[k];
            chk("rdata", rdat_k, last_rd[k]);
            rv_exp[k] = 1'b0;
        end

        issuing = -1;
        if (read || write) begin
            chk("strobe_width", prev_strobe, 0);
            if (read) chk("read_dw_zero", data_write, 0);
            hit = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (hit < 0 && sb[i].a.we == write && sb[i].a.ad == addr &&
                    (!write || sb[i].a.wd == data_write)) hit = i;
            end
            chk("access_expected", {31'd0, hit >= 0}, 1);
            if (hit >= 0) begin
                issuing = int'(sb[hit].k);
                served.push_back(issuing);
                n_srv++;
                if (read) begin
                    rv_exp[issuing] = 1'b1;
                    rd_exp[issuing] = rd_model(addr);
                end
                sb.delete(hit);
            end
            last_addr = addr;
            last_dw   = data_write;
        end else begin
            chk("addr_hold", addr, last_addr);
            chk("dw_hold", data_write, last_dw);
        end
        prev_strobe = read || write;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   w;
        logic busy_k, rv_k;
        logic [DW-1:0] rdat_k;

        tbl[0] = '{k: 0, we: 1'b1, ad: 6'h05, wd: 8'hA5, exp_dw: 8'hA5, exp_rd: 8'h00};
        tbl[1] = '{k: 1, we: 1'b0, ad: 6'h12, wd: 8'h77, exp_dw: 8'h00, exp_rd: 8'h3C};
        tbl[2] = '{k: 0, we: 1'b0, ad: 6'h3F, wd: 8'h00, exp_dw: 8'h00, exp_rd: 8'h11};
        tbl[3] = '{k: 1, we: 1'b1, ad: 6'h2A, wd: 8'h5A, exp_dw: 8'h5A, exp_rd: 8'h3C};
        tbl[4] = '{k: 0, we: 1'b1, ad: 6'h00, wd: 8'hFF, exp_dw: 8'hFF, exp_rd: 8'h11};
        tbl[5] = '{k: 1, we: 1'b0, ad: 6'h00, wd: 8'h00, exp_dw: 8'h00, exp_rd: 8'h2E};

        rst_n = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        n_acc = 0;
        n_srv = 0;
        model_reset();
        #1;
        check_reset_outs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Single transactions: strobe after the second edge, read data after the third.
        for (int i = 0; i < 6; i++) begin
            set_req(tbl[i].k, tbl[i].we, tbl[i].ad, tbl[i].wd);
            cyc();
            busy_k = (tbl[i].k == 0) ? r0_busy : r1_busy;
            chk("tbl_no_early_strobe", {31'd0, read || write}, 0);
            chk("tbl_busy", busy_k, 1);
            cyc();
            chk("tbl_write", write, tbl[i].we);
            chk("tbl_read", read, !tbl[i].we);
            chk("tbl_addr", addr, tbl[i].ad);
            chk("tbl_dw", data_write, tbl[i].exp_dw);
            cyc();
            rv_k   = (tbl[i].k == 0) ? r0_rvalid : r1_rvalid;
            rdat_k = (tbl[i].k == 0) ? r0_rdata  : r1_rdata;
            chk("tbl_rvalid", rv_k, !tbl[i].we);
            chk("tbl_rdata", rdat_k, tbl[i].exp_rd);
            chk("tbl_strobe_off", {31'd0, read || write}, 0);
            cyc();
        end

        // Back-to-back request on a held slot is dropped.
        served.delete();
        set_req(0, 1'b1, 6'h08, 8'h11);
        cyc();
        set_req(0, 1'b1, 6'h09, 8'h22);
        cyc();
        chk("ovf_pulse", r0_ovf, 1);
        chk("ovf_first_addr", addr, 6'h08);
        cyc();
        chk("ovf_one_cycle", r0_ovf, 0);
        repeat (3) cyc();
        chk("ovf_one_access", served.size(), 1);

        // Request landing on the releasing edge is taken without overflow.
        served.delete();
        set_req(0, 1'b1, 6'h0A, 8'h33);
        cyc();
        cyc();
        set_req(0, 1'b0, 6'h0B, 8'h00);
        cyc();
        chk("reledge_no_ovf", r0_ovf, 0);
        chk("reledge_busy", r0_busy, 1);
        cyc();
        chk("reledge_read", read, 1);
        chk("reledge_addr", addr, 6'h0B);
        cyc();
        chk("reledge_rvalid", r0_rvalid, 1);
        chk("reledge_rdata", r0_rdata, 8'h25);
        cyc();
        chk("reledge_count", served.size(), 2);

        // Reset in the middle of a read access aborts it.
        set_req(1, 1'b0, 6'h12, 8'h00);
        cyc();
        cyc();
        chk("abort_read_up", read, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outs();
        @(posedge clk);
        #1 chk("abort_no_rv", r1_rvalid, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        served.delete();
        repeat (6) cyc();
        chk("abort_no_replay", served.size(), 0);

        // Ties: first after reset goes to r0, then alternation against last grant.
        served.delete();
        set_req(0, 1'b1, 6'h10, 8'h44);
        set_req(1, 1'b0, 6'h21, 8'h00);
        repeat (6) cyc();
        chk("tie1_count", served.size(), 2);
        chk("tie1_first", served[0], 0);
        chk("tie1_second", served[1], 1);
        set_req(0, 1'b1, 6'h14, 8'h55);
        repeat (4) cyc();
        served.delete();
        set_req(0, 1'b0, 6'h16, 8'h00);
        set_req(1, 1'b1, 6'h23, 8'h66);
        repeat (6) cyc();
        chk("tie2_count", served.size(), 2);
        chk("tie2_first", served[0], 1);
        chk("tie2_second", served[1], 0);

        // Random traffic; r0 uses even addresses and r1 odd ones so accesses are attributable.
        n_acc = 0;
        n_srv = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(1, 0) == 1)
                set_req(0, 1'($urandom), {5'($urandom), 1'b0}, 8'($urandom));
            if ($urandom_range(1, 0) == 1)
                set_req(1, 1'($urandom), {5'($urandom), 1'b1}, 8'($urandom));
            cyc();
        end
        w = 0;
        while ((sb.size() != 0 || pend[0] || pend[1]) && w < 20) begin
            cyc();
            w++;
        end
        cyc();
        chk("rand_drained", sb.size(), 0);
        chk("rand_served_once", n_srv, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
